// File: rtl/div_unit.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per cycle.
// Handles signed and unsigned operands via magnitudes plus sign fix-up.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, FINISH} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quo, dmag, raw_dividend;
   logic             q_sign, r_sign, zero_divisor;

   logic             accept, neg_a, neg_b, trial_ok;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, diff;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            if (start) state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (count == CW'(WIDTH - 1)) state_next = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            state_next = FINISH;
         end
         FINISH: begin
            done       = 1'b1;
            accept     = start;
            state_next = start ? CALC : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand magnitudes and the trial subtract. The (WIDTH+1)-bit difference
   // wraps negative exactly when the shifted remainder is below the divisor.
   always_comb begin
      neg_a    = signed_op & dividend[WIDTH-1];
      neg_b    = signed_op & divisor[WIDTH-1];
      a_mag    = neg_a ? -dividend : dividend;
      b_mag    = neg_b ? -divisor : divisor;
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - {1'b0, dmag};
      trial_ok = ~diff[WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count        <= '0;
         rem          <= '0;
         quo          <= '0;
         dmag         <= '0;
         raw_dividend <= '0;
         q_sign       <= 1'b0;
         r_sign       <= 1'b0;
         zero_divisor <= 1'b0;
         quotient     <= '0;
         remainder    <= '0;
         div_by_zero  <= 1'b0;
      end else begin
         if (accept) begin
            count        <= '0;
            rem          <= '0;
            quo          <= a_mag;
            dmag         <= b_mag;
            raw_dividend <= dividend;
            q_sign       <= neg_a ^ neg_b;
            r_sign       <= neg_a;
            zero_divisor <= (divisor == '0);
         end else if (state == CALC) begin
            count <= count + CW'(1);
            rem   <= trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], trial_ok};
         end else if (state == FIX) begin
            // A zero divisor overrides whatever the magnitude loop produced.
            if (zero_divisor) begin
               quotient    <= '1;
               remainder   <= raw_dividend;
               div_by_zero <= 1'b1;
            end else begin
               quotient    <= q_sign ? -quo : quo;
               remainder   <= r_sign ? -rem : rem;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus handshake and reset sequences.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset_n, start, signed_op;
   logic [31:0] dividend, divisor;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        sop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t vecs[12];

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .signed_op(signed_op),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Waits up to 60 edges for done; lat is the edge count, 0 on timeout.
   task automatic waitDone(output int lat);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic applyStimulus(input logic sop, input logic [31:0] a,
                                input logic [31:0] b, output int lat);
      @(negedge clk);
      signed_op = sop; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ~sop;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      waitDone(lat);
   endtask

   initial begin
      int lat, lat2, done_seen;

      vecs[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
      vecs[3]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
      vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'h10,       32'h0FFFFFFF, 32'hF,        1'b0};
      vecs[5]  = '{1'b1, 32'hFFFFFFFF,  32'h10,       32'd0,        32'hFFFFFFFF, 1'b0};
      vecs[6]  = '{1'b0, 32'h12345678,  32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
      vecs[7]  = '{1'b1, 32'h12345678,  32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
      vecs[8]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
      vecs[9]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
      vecs[10] = '{1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
      vecs[11] = '{1'b0, 32'd5,         32'd9,        32'd0,        32'd5,        1'b0};

      reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_quotient", quotient, 32'd0);
      checkOutput("reset_remainder", remainder, 32'd0);
      checkOutput("reset_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk) reset_n = 1'b1;

      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].sop, vecs[v].a, vecs[v].b, lat);
         $display("[TB] vector %0d latency=%0d q=%h r=%h", v, lat, quotient, remainder);
         checkOutput("latency", 32'(lat), 32'd33);
         checkOutput("busy_in_done", 32'(busy), 32'd0);
         checkOutput("quotient", quotient, vecs[v].q);
         checkOutput("remainder", remainder, vecs[v].r);
         checkOutput("div_by_zero", 32'(div_by_zero), 32'(vecs[v].dz));
         @(posedge clk); #1;
         checkOutput("done_pulse_len", 32'(done), 32'd0);
         checkOutput("quotient_held", quotient, vecs[v].q);
      end

      // START re-asserted mid-operation must be ignored.
      @(negedge clk);
      signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         if (i == 10) begin
            start = 1'b1; dividend = 32'd50; divisor = 32'd5; signed_op = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      checkOutput("ignore_latency", 32'(lat), 32'd33);
      checkOutput("ignore_quotient", quotient, 32'd14);
      checkOutput("ignore_remainder", remainder, 32'd2);
      @(posedge clk); #1;
      checkOutput("ignore_no_restart", 32'(busy), 32'd0);

      // Back-to-back: START held through the DONE cycle.
      applyStimulus(1'b0, 32'd20, 32'd3, lat);
      checkOutput("b2b_first_latency", 32'(lat), 32'd33);
      checkOutput("b2b_first_quotient", quotient, 32'd6);
      checkOutput("b2b_first_remainder", remainder, 32'd2);
      signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("b2b_accepted", 32'(busy), 32'd1);
      checkOutput("b2b_done_low", 32'(done), 32'd0);
      waitDone(lat2);
      checkOutput("b2b_spacing", 32'(lat2 == 0 ? 0 : lat2 + 1), 32'd34);
      checkOutput("b2b_second_quotient", quotient, 32'd100);
      checkOutput("b2b_second_remainder", remainder, 32'd0);

      // Reset mid-operation aborts with no DONE and zeroed outputs.
      @(negedge clk);
      signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk) reset_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_quotient", quotient, 32'd0);
      checkOutput("abort_remainder", remainder, 32'd0);
      checkOutput("abort_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      checkOutput("abort_no_done", 32'(done_seen), 32'd0);
      applyStimulus(1'b0, 32'd9, 32'd3, lat);
      checkOutput("post_reset_latency", 32'(lat), 32'd33);
      checkOutput("post_reset_quotient", quotient, 32'd3);
      checkOutput("post_reset_remainder", remainder, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
